// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative 32-cycle multiply/divide unit producing the HI/LO write stream
module hilo_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  input  logic        cancel,
  output logic        busy,
  output logic        fg_write,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_n;
  logic [4:0] cnt;
  logic [31:0] hi_r, lo_r, b_r;
  logic is_div, neg_q, neg_r;
  logic sgn, a_neg, b_neg, md_go, dge;
  logic [31:0] a_mag, b_mag, ddiff;
  logic [32:0] msum, dsh;
  logic [63:0] prod;
  // operand conditioning and one iteration step of either algorithm
  always_comb begin
    sgn = !op[0];
    a_neg = sgn & src_a[31];
    b_neg = sgn & src_b[31];
    a_mag = a_neg ? -src_a : src_a;
    b_mag = b_neg ? -src_b : src_b;
    md_go = start & !cancel & !op[2];
    msum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : 33'd0);
    dsh = {hi_r, lo_r[31]};
    dge = dsh >= {1'b0, b_r};
    ddiff = dsh[31:0] - b_r;
    prod = neg_q ? -{hi_r, lo_r} : {hi_r, lo_r};
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next state: cancel always wins and returns to IDLE
  always_comb begin
    state_n = cancel ? IDLE :
              state == IDLE ? (md_go ? RUN : IDLE) :
              state == RUN ? (cnt == 5'd31 ? FIN : RUN) : IDLE;
  end
  // outputs decoded from state
  always_comb begin
    busy = state != IDLE;
  end
  // datapath: operand latch, iterations, sign fixup and HI/LO write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 5'd0;
      hi_r <= 32'd0;
      lo_r <= 32'd0;
      b_r <= 32'd0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      fg_write <= 1'b0;
      out_hi <= 32'd0;
      out_lo <= 32'd0;
    end else begin
      fg_write <= 1'b0;
      if (state == IDLE && start && !cancel) begin
        if (op == 3'b100) begin
          fg_write <= 1'b1;
          out_hi <= src_a;
          out_lo <= cur_lo;
        end else if (op == 3'b101) begin
          fg_write <= 1'b1;
          out_hi <= cur_hi;
          out_lo <= src_a;
        end else if (!op[2]) begin
          cnt <= 5'd0;
          hi_r <= 32'd0;
          lo_r <= a_mag;
          b_r <= b_mag;
          is_div <= op[1];
          neg_q <= (a_neg ^ b_neg) & (!op[1] | (src_b != 32'd0));
          neg_r <= a_neg;
        end
      end else if (state == RUN) begin
        cnt <= cnt + 5'd1;
        hi_r <= is_div ? (dge ? ddiff : dsh[31:0]) : msum[32:1];
        lo_r <= is_div ? {lo_r[30:0], dge} : {msum[0], lo_r[31:1]};
      end else if (state == FIN && !cancel) begin
        fg_write <= 1'b1;
        out_hi <= is_div ? (neg_r ? -hi_r : hi_r) : prod[63:32];
        out_lo <= is_div ? (neg_q ? -lo_r : lo_r) : prod[31:0];
      end
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: randomized and directed checks of hilo_muldiv against a behavioural model
module tb_hilo_muldiv;
  logic clk = 0, rst = 1, start = 0, cancel = 0;
  logic [2:0] op = 0;
  logic [31:0] src_a = 0, src_b = 0, cur_hi = 0, cur_lo = 0;
  logic busy, fg_write;
  logic [31:0] out_hi, out_lo;

  hilo_muldiv dut (.clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
                   .cur_hi(cur_hi), .cur_lo(cur_lo), .cancel(cancel), .busy(busy),
                   .fg_write(fg_write), .out_hi(out_hi), .out_lo(out_lo));

  always #5 clk = ~clk;

  int cyc = 0, checks = 0, errors = 0;
  int busy_start = -1, busy_end = -1, pend_cyc = -1;
  bit pend_wr = 0;
  logic [31:0] pend_hi = 0, pend_lo = 0, hold_hi = 0, hold_lo = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint p;
    sa = a;
    sb = b;
    if (o == 3'd0) begin
      p = longint'(sa) * longint'(sb);
      return p;
    end
    if (o == 3'd1) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (o == 3'd3) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // per-cycle comparison of every output against the model's expectation
  always @(posedge clk) begin
    cyc++;
    #1;
    if (cyc == pend_cyc) begin
      hold_hi = pend_hi;
      hold_lo = pend_lo;
    end
    chk("busy", busy, busy_start <= cyc && cyc <= busy_end);
    chk("fg_write", fg_write, cyc == pend_cyc && pend_wr);
    chk("out_hi", out_hi, hold_hi);
    chk("out_lo", out_lo, hold_lo);
  end

  task automatic model_issue(input logic [2:0] o, input logic [31:0] a, b, h, l);
    if (o == 3'd4 || o == 3'd5) begin
      pend_cyc = cyc + 1;
      pend_wr = 1;
      pend_hi = (o == 3'd4) ? a : h;
      pend_lo = (o == 3'd4) ? l : a;
    end else if (o < 3'd4) begin
      busy_start = cyc + 1;
      busy_end = cyc + 33;
      pend_cyc = cyc + 34;
      pend_wr = 1;
      {pend_hi, pend_lo} = model(o, a, b);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, b, h, l, input bit can);
    op = o; src_a = a; src_b = b; cur_hi = h; cur_lo = l; start = 1; cancel = can;
    if (!can) model_issue(o, a, b, h, l);
    @(negedge clk);
    start = 0; cancel = 0;
  endtask

  task automatic wait_idle(input int cat, input bit noise);
    while (cyc <= busy_end) begin
      if (cyc == cat) begin
        cancel = 1;
        busy_end = cyc;
        pend_cyc = -1;
      end
      if (noise && $urandom_range(0, 3) == 0) begin
        op = 3'($urandom_range(0, 7));
        src_a = $urandom;
        start = 1;
      end
      @(negedge clk);
      start = 0; cancel = 0;
    end
  endtask

  task automatic pin_op(input string n, input logic [2:0] o, input logic [31:0] a, b,
                        input logic [31:0] ehi, elo);
    int nb;
    chk({n, "_model"}, model(o, a, b), {ehi, elo});
    issue(o, a, b, 32'h0, 32'h0, 0);
    nb = 0;
    repeat (33) begin
      nb += int'(busy);
      @(negedge clk);
    end
    chk({n, "_busy_cycles"}, nb, 33);
    chk({n, "_fg"}, fg_write, 1);
    chk({n, "_result"}, {out_hi, out_lo}, {ehi, elo});
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_out", {out_hi, out_lo}, 64'd0);
    chk("reset_busy", busy, 0);
    pin_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    pin_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    pin_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    pin_op("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    pin_op("div_7_0", 3'd2, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    pin_op("div_neg_0", 3'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    pin_op("divu_x_0", 3'd3, 32'h89ABCDEF, 32'd0, 32'h89ABCDEF, 32'hFFFFFFFF);
    pin_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    issue(3'd4, 32'hDEADBEEF, 32'd0, 32'h0, 32'h12345678, 0);
    chk("mthi_fg", fg_write, 1);
    chk("mthi_data", {out_hi, out_lo}, {32'hDEADBEEF, 32'h12345678});
    chk("mthi_busy", busy, 0);
    @(negedge clk);
    c = cyc;
    issue(3'd0, 32'd6, 32'd7, 32'h0, 32'h0, 0);
    wait_idle(c + 10, 0);
    chk("cancel_idle", busy, 0);
    repeat (40) @(negedge clk);
    pin_op("divu_9_3", 3'd3, 32'd9, 32'd3, 32'd0, 32'd3);
    c = cyc;
    issue(3'd3, 32'd1000, 32'd7, 32'h0, 32'h0, 0);
    while (cyc < c + 20) begin
      if (cyc == c + 5) begin
        op = 3'd5; src_a = 32'hCAFEF00D; start = 1;
      end
      @(negedge clk);
      start = 0;
    end
    rst = 1;
    busy_start = -1; busy_end = -1;
    pend_cyc = cyc + 1; pend_wr = 0; pend_hi = 0; pend_lo = 0;
    @(negedge clk);
    rst = 0;
    chk("midrst_out", {out_hi, out_lo}, 64'd0);
    chk("midrst_busy", busy, 0);
    repeat (40) @(negedge clk);
    for (int n = 0; n < 250; n++) begin
      logic [2:0] o;
      logic [31:0] a, b, h, l;
      bit can_now;
      int cat;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      o = 3'($urandom_range(0, 7));
      a = rnd32(); b = rnd32(); h = $urandom; l = $urandom;
      can_now = ($urandom_range(0, 15) == 0);
      c = cyc;
      cat = ($urandom_range(0, 7) == 0) ? c + $urandom_range(1, 33) : -1;
      issue(o, a, b, h, l, can_now);
      wait_idle(cat, 1);
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide unit that produces the HI/LO write stream for the CPU's HI/LO register pair. Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the execute stage. It runs multiply and divide over a fixed 32-iteration sequence. On completion it drives a one-cycle write strobe, `fg_write`, with the full 64-bit HI/LO value. Downstream, `fg_write`, `out_hi` and `out_lo` connect directly to the HI/LO register's write enable and data inputs.

## Interface
- No parameters; datapath fixed at 32 bits.
- Reset is `rst`, synchronous, active-high. Clock is `clk`.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops and are ignored.
- `src_a` in 32: multiplicand / dividend / MTHI–MTLO data.
- `src_b` in 32: multiplier / divisor.
- `cur_hi` in 32: current HI register value, used to preserve HI on MTLO.
- `cur_lo` in 32: current LO register value, used to preserve LO on MTHI.
- `cancel` in 1: pipeline flush; aborts any operation in flight.
- `busy` out 1: high while state is not IDLE.
- `fg_write` out 1: registered, one-cycle HI/LO write strobe.
- `out_hi` out 32: registered HI write data.
- `out_lo` out 32: registered LO write data.

## Operation
- States:
  - IDLE: accepts `start`.
  - RUN: 32 iterations, counter 0..31.
  - FIN: sign correction and output register load.
- Reset values: state IDLE, counter 0, `busy`=0, `fg_write`=0, `out_hi`=0, `out_lo`=0. Internal accumulators are cleared.
- IDLE with `start`=1 and `cancel`=0:
  - MTHI: load `out_hi`=`src_a`, `out_lo`=`cur_lo`, `fg_write`<=1. Stay in IDLE.
  - MTLO: load `out_hi`=`cur_hi`, `out_lo`=`src_a`, `fg_write`<=1. Stay in IDLE.
  - MULT/MULTU/DIV/DIVU: latch operand magnitudes into working registers, then go to RUN with counter 0.
    - For signed ops, the magnitude is the two's-complement absolute value.
    - Latch the result-negate flag and the dividend-sign flag.
  - Undefined op: no action.
- Multiply (RUN): shift-add, one multiplier bit per cycle, LSB first, into a 64-bit accumulator.
- Divide (RUN): restoring division, one quotient bit per cycle, MSB first. Uses a 33-bit partial remainder.
- Counter reaching 31 at a clock edge: go to FIN.
- FIN: one cycle, then IDLE with `fg_write`<=1.
  - Multiply: {`out_hi`,`out_lo`} = 64-bit product, negated if the latched negate flag is set (signed ops, operand signs differ).
  - Divide: `out_lo` = quotient, negated if the divisor and dividend signs differ. `out_hi` = remainder, negated if the dividend is negative.
- Divide by zero (`src_b`=0): no exception and same latency. Result is `out_lo`=32'hFFFFFFFF, `out_hi`=`src_a`, for both DIV and DIVU.
- DIV 32'h80000000 / 32'hFFFFFFFF: `out_lo`=32'h80000000, `out_hi`=0. No exception.
- `fg_write` is high for exactly one cycle per completed operation and is never high otherwise. `out_hi`/`out_lo` hold their values until the next load.
- `start` while `busy`=1: ignored. The issuing stage must stall while `busy`=1.
- `cancel`:
  - In RUN or FIN: return to IDLE on the next edge. No `fg_write`; outputs are unchanged.
  - Together with `start` in IDLE: the start is dropped.
  - `cancel` overrides the FIN write.
- `rst` mid-operation: behaves as the reset values, with no write.

## Timing
- Multiply/divide, start sampled at edge 0:
  - `busy` is high in cycles 1..33: 32 RUN cycles, then FIN.
  - `fg_write` and the results are valid in cycle 34 only.
  - `busy` is already 0 in cycle 34, so a new `start` is accepted in cycle 34.
- MTHI/MTLO, sampled at edge 0: `fg_write` is high in cycle 1; `busy` stays 0.
- MFHI/MFLO hazard: the consumer must stall while `busy`=1 or `fg_write`=1. The HI/LO register updates on the edge ending the `fg_write` cycle.

## Test plan
- MULT src_a=32'hFFFFFFFD (-3), src_b=5 -> cycle 34: `fg_write`=1, `out_hi`=32'hFFFFFFFF, `out_lo`=32'hFFFFFFF1. `busy` is high for exactly 33 cycles.
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF -> `out_hi`=32'hFFFFFFFE, `out_lo`=32'h00000001.
- DIVU 100/7 -> `out_lo`=14, `out_hi`=2. DIV -7/2 -> `out_lo`=32'hFFFFFFFD, `out_hi`=32'hFFFFFFFF. DIV 7/0 -> `out_lo`=32'hFFFFFFFF, `out_hi`=7.
- MTHI src_a=32'hDEADBEEF, cur_lo=32'h12345678 -> next cycle `fg_write`=1, `out_hi`=32'hDEADBEEF, `out_lo`=32'h12345678, `busy` never high.
- Start MULT 6×7, assert `cancel` in cycle 10 -> IDLE in cycle 11, no `fg_write` ever. A subsequent DIVU 9/3 yields `out_lo`=3, `out_hi`=0.
- Start DIVU, pulse `start` with MTLO at cycle 5, then assert `rst` at cycle 20 -> MTLO ignored. After reset all outputs are 0 and `busy`=0, with no `fg_write`.
